// File: rtl/router_fifo_if.sv
// router_fifo_if: write/read handshake and status bundle of one router output port.
// The slave modport is the FIFO side; the master modport is the synchronizer/client side.
interface router_fifo_if #(
  parameter int DATA_W = 8
);
  logic              we;
  logic              lfd;
  logic [DATA_W-1:0] din;
  logic              re;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              pkt_busy;
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output we, lfd, din, re,
    input  dout, full, empty, pkt_busy, ovf_err, udf_err
  );

  modport slave (
    input  we, lfd, din, re,
    output dout, full, empty, pkt_busy, ovf_err, udf_err
  );
endinterface

// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer of the 1x3 router.
// Each entry stores a data byte plus a header marker (lfd); the packet counter is
// loaded from a header's length field when that header is popped, so pkt_busy
// tells the client that bytes of the current packet are still owed.
// Optional feature: define ROUTER_FIFO_ERR_EN to build sticky overflow/underflow
// flags; otherwise ovf_err/udf_err are tied low.
// The length field is taken from the top six data bits, so DATA_W must be >= 8.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           srst,
  router_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [6:0]        pkt_cnt;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W:0]   rd_entry;
  logic              clr;
  logic              full;
  logic              empty;
  logic              wr_ok;
  logic              rd_ok;

  // Hard and soft reset produce the same cleared state; either one blocks requests.
  assign clr      = rst || srst;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wr_ok    = bus.we && !full && !clr;
  assign rd_ok    = bus.re && !empty && !clr;
  assign rd_entry = mem[rd_ptr];

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.dout     = dout_q;
  assign bus.pkt_busy = (pkt_cnt != 7'd0);

  // Storage array: written on accepted writes only, never cleared by any reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {bus.lfd, bus.din};
    end
  end

  // Pointers, occupancy, registered read data and packet counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
      dout_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        dout_q <= rd_entry[DATA_W-1:0];
        if (rd_entry[DATA_W]) begin
          // Header length counts payload bytes; one more for the parity byte.
          pkt_cnt <= {1'b0, rd_entry[DATA_W-1:DATA_W-6]} + 7'd1;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt <= pkt_cnt - 7'd1;
        end
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;

  // Sticky error flags: record any attempted write while full or read while empty.
  always_ff @(posedge clk) begin
    if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.we && full) begin
        ovf_q <= 1'b1;
      end
      if (bus.re && empty) begin
        udf_q <= 1'b1;
      end
    end
  end
`else
  assign bus.ovf_err = 1'b0;
  assign bus.udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed scoreboard bench for router_fifo.
// Stimulus pushes expected read bytes into a queue; an independent monitor pops
// and compares whenever the DUT accepts a read. Status flags are checked directly.
module tb_router_fifo;

  localparam int DEPTH = 16;
`ifdef ROUTER_FIFO_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic rst;
  logic srst;

  int total;
  int bad;

  logic [7:0] exp_q[$];
  logic [8:0] model_q[$];
  logic       m_ovf;
  logic       m_udf;

  router_fifo_if #(.DATA_W(8)) bus();

  router_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .srst (srst),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests and advance the reference model by the same cycle.
  task automatic apply_stimulus(input logic we, input logic lfd, input logic [7:0] din,
                                input logic re, input logic sr, input logic hr);
    logic [8:0] e;
    logic       rd_m;
    logic       wr_m;
    bus.we  = we;
    bus.lfd = lfd;
    bus.din = din;
    bus.re  = re;
    srst    = sr;
    rst     = hr;
    if (sr || hr) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_m = re && (model_q.size() != 0);
      wr_m = we && (model_q.size() != DEPTH);
      if (we && model_q.size() == DEPTH) m_ovf = 1'b1;
      if (re && model_q.size() == 0) m_udf = 1'b1;
      if (rd_m) begin
        e = model_q.pop_front();
        exp_q.push_back(e[7:0]);
      end
      if (wr_m) model_q.push_back({lfd, din});
    end
    @(posedge clk);
    #1;
    bus.we  = 1'b0;
    bus.lfd = 1'b0;
    bus.re  = 1'b0;
    srst    = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic write_byte(input logic lfd, input logic [7:0] d);
    apply_stimulus(1'b1, lfd, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_byte();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_errs(input string tag);
    check_output({tag, "_ovf"}, 32'(bus.ovf_err), 32'(m_ovf & EXP_ERR));
    check_output({tag, "_udf"}, 32'(bus.udf_err), 32'(m_udf & EXP_ERR));
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_empty"}, 32'(bus.empty), 32'd1);
    check_output({tag, "_full"}, 32'(bus.full), 32'd0);
    check_output({tag, "_pkt_busy"}, 32'(bus.pkt_busy), 32'd0);
    check_output({tag, "_dout"}, 32'(bus.dout), 32'h00);
    check_output({tag, "_ovf"}, 32'(bus.ovf_err), 32'd0);
    check_output({tag, "_udf"}, 32'(bus.udf_err), 32'd0);
  endtask

  // Monitor: decide at the falling edge whether the next edge pops, then compare dout.
  initial begin
    logic       acc;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      acc = bus.re && !bus.empty && !rst && !srst;
      @(posedge clk);
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_read: got dout 0x%0h expected no read", bus.dout);
        end else begin
          e = exp_q.pop_front();
          check_output("read_data", 32'(bus.dout), 32'(e));
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    total   = 0;
    bad     = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    bus.we  = 1'b0;
    bus.lfd = 1'b0;
    bus.din = 8'h00;
    bus.re  = 1'b0;
    srst    = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_cleared("reset");

    // Header 0x0C (length 3), three payload bytes, parity byte.
    write_byte(1'b1, 8'h0C);
    check_output("first_write_empty", 32'(bus.empty), 32'd0);
    write_byte(1'b0, 8'h11);
    write_byte(1'b0, 8'h22);
    write_byte(1'b0, 8'h33);
    write_byte(1'b0, 8'h0C);
    read_byte();
    check_output("hdr_pop_busy", 32'(bus.pkt_busy), 32'd1);
    read_byte();
    read_byte();
    read_byte();
    check_output("pkt_4th_busy", 32'(bus.pkt_busy), 32'd1);
    read_byte();
    check_output("pkt_5th_busy", 32'(bus.pkt_busy), 32'd0);
    check_output("pkt_end_empty", 32'(bus.empty), 32'd1);

    // Fill to 16, then an overflow write that must be dropped.
    for (int i = 0; i < 16; i++) write_byte(1'b0, 8'(8'h40 + i));
    check_output("fill_full", 32'(bus.full), 32'd1);
    write_byte(1'b0, 8'hEE);
    check_output("ovf_full", 32'(bus.full), 32'd1);
    check_output("ovf_dout_hold", 32'(bus.dout), 32'h0C);
    check_output("ovf_err", 32'(bus.ovf_err), 32'(EXP_ERR));
    for (int i = 0; i < 16; i++) read_byte();
    check_output("drain_empty", 32'(bus.empty), 32'd1);
    check_output("drain_busy", 32'(bus.pkt_busy), 32'd0);

    // Full FIFO with simultaneous write and read: read wins, write dropped.
    for (int i = 0; i < 16; i++) write_byte(1'b0, 8'(8'h60 + i));
    apply_stimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
    check_output("full_rw_full", 32'(bus.full), 32'd0);
    for (int i = 0; i < 15; i++) read_byte();
    check_output("full_rw_empty", 32'(bus.empty), 32'd1);

    // Empty FIFO with simultaneous write and read: write wins, dout holds.
    apply_stimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    check_output("empty_rw_empty", 32'(bus.empty), 32'd0);
    check_output("empty_rw_dout", 32'(bus.dout), 32'h6F);
    check_errs("empty_rw");
    read_byte();
    check_output("a5_empty", 32'(bus.empty), 32'd1);
    read_byte();
    check_output("udf_dout_hold", 32'(bus.dout), 32'hA5);
    check_errs("udf");

    // Pointer wrap: steady occupancy 3 across 40 paired operations.
    write_byte(1'b0, 8'h90);
    write_byte(1'b0, 8'h91);
    write_byte(1'b0, 8'h92);
    for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 1'b0, 8'(8'hB0 + i), 1'b1, 1'b0, 1'b0);
    check_output("wrap_not_empty", 32'(bus.empty), 32'd0);
    for (int i = 0; i < 3; i++) read_byte();
    check_output("wrap_empty", 32'(bus.empty), 32'd1);

    // Soft reset mid-packet: header length 4 gives pkt_cnt 5 with 8 entries left.
    write_byte(1'b1, 8'h10);
    for (int i = 0; i < 8; i++) write_byte(1'b0, 8'(8'hC0 + i));
    read_byte();
    check_output("srst_pre_busy", 32'(bus.pkt_busy), 32'd1);
    apply_stimulus(1'b1, 1'b0, 8'hDD, 1'b1, 1'b1, 1'b0);
    check_cleared("srst");

    // Same scenario with both resets asserted together, after setting udf.
    read_byte();
    write_byte(1'b1, 8'h10);
    for (int i = 0; i < 8; i++) write_byte(1'b0, 8'(8'hE0 + i));
    read_byte();
    check_output("both_pre_busy", 32'(bus.pkt_busy), 32'd1);
    apply_stimulus(1'b1, 1'b0, 8'hDD, 1'b1, 1'b1, 1'b1);
    check_cleared("both_rst");

    // Post-reset sanity: the FIFO restarts cleanly.
    write_byte(1'b0, 8'h5A);
    read_byte();
    check_output("post_rst_empty", 32'(bus.empty), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
